// File: rtl/line_memory_responder_if.sv
// rtl/line_memory_responder_if.sv - cache-to-memory line request/response bundle
//
// Purpose: groups the hold-until-response line interface between a cache
// controller (master) and a line memory (slave).
// Signals:
//   pmem_read, pmem_write  request strobes, held by the master until pmem_resp
//   pmem_address [31:0]    byte address of the line
//   pmem_wdata   [255:0]   line to write
//   pmem_rdata   [255:0]   line returned by a read
//   pmem_resp              one-cycle completion pulse
interface line_memory_responder_if;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  modport master (
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport slave (
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/line_memory_responder.sv
// rtl/line_memory_responder.sv - fixed-latency line memory answering the cache downstream port
//
// Purpose: accepts one line read or write, spends LATENCY cycles busy, then
// pulses pmem_resp for one cycle with the read line (if a read).
// Ports:
//   clk          clock, rising edge
//   rst_n        synchronous active-low reset (array contents are kept)
//   bus          line interface, slave side
//   proto_error  sticky flag: read+write together at accept, or request
//                dropped while busy; cleared only by reset
module line_memory_responder #(
  parameter int LATENCY     = 4,
  parameter int DEPTH_LINES = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  line_memory_responder_if.slave   bus,
  output logic                     proto_error
);

  localparam int IDX_W = $clog2(DEPTH_LINES);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               op_write;
  logic [IDX_W-1:0]   idx;
  logic [255:0]       wdata_q;
  logic [255:0]       rdata_q;
  logic [255:0]       mem [DEPTH_LINES];

  logic req_held;
  logic commit;
  logic unused_addr;

  assign req_held = bus.pmem_read | bus.pmem_write;

  // The line is written on the BUSY->RESP edge only; a reset on that same
  // edge aborts the transaction, so the write is gated by rst_n.
  assign commit = rst_n && (state == BUSY) && req_held && (cnt == '0) && op_write;

  assign bus.pmem_resp  = (state == RESP);
  assign bus.pmem_rdata = rdata_q;

  // Only the line-index bits are decoded; higher bits alias by design.
  assign unused_addr = ^bus.pmem_address;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      op_write    <= 1'b0;
      idx         <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      proto_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_held) begin
            // Write wins when both strobes are high.
            op_write <= bus.pmem_write;
            idx      <= bus.pmem_address[5 +: IDX_W];
            wdata_q  <= bus.pmem_wdata;
            cnt      <= CNT_LOAD;
            state    <= BUSY;
            if (bus.pmem_read && bus.pmem_write) begin
              proto_error <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (!req_held) begin
            // Initiator abandoned the transaction: no commit, no response.
            proto_error <= 1'b1;
            cnt         <= '0;
            state       <= IDLE;
          end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state <= RESP;
            if (!op_write) begin
              rdata_q <= mem[idx];
            end
          end
        end
        RESP: begin
          // The initiator still holds its request here; returning to IDLE
          // first keeps it from being accepted twice.
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (commit) begin
      mem[idx] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_line_memory_responder.sv
// tb/tb_line_memory_responder.sv - scoreboard bench for line_memory_responder
module tb_line_memory_responder;

  localparam int LAT = 4;

  typedef struct {
    int           cyc;
    bit           is_read;
    logic [255:0] data;
  } exp_t;

  logic clk;
  logic rst_n;
  logic proto_error;
  int   cyc;
  int   n_vec;
  int   n_err;
  exp_t sb[$];

  line_memory_responder_if bus ();

  line_memory_responder #(
    .LATENCY     (LAT),
    .DEPTH_LINES (256)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .proto_error (proto_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every response pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (bus.pmem_resp === 1'b1) begin
      n_vec = n_vec + 1;
      if (sb.size() == 0) begin
        n_err = n_err + 1;
        $display("FAIL resp_unexpected: pmem_resp=1 at cycle %0d, required no response", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (cyc != e.cyc || (e.is_read && bus.pmem_rdata !== e.data)) begin
          n_err = n_err + 1;
          $display("FAIL resp_%s: cycle %0d rdata %h, required cycle %0d rdata %h",
                   e.is_read ? "read" : "write", cyc, bus.pmem_rdata, e.cyc,
                   e.is_read ? e.data : bus.pmem_rdata);
        end
      end
    end
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    n_vec = n_vec + 1;
    if (act !== req) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; holds the request until pmem_resp.
  task automatic issue(input bit rd, input bit wr, input logic [31:0] a,
                       input logic [255:0] wd, input logic [255:0] exp_rd);
    exp_t e;
    bit   got;
    bus.pmem_read    = rd;
    bus.pmem_write   = wr;
    bus.pmem_address = a;
    bus.pmem_wdata   = wd;
    e.cyc     = cyc + LAT + 1;
    e.is_read = rd && !wr;
    e.data    = exp_rd;
    sb.push_back(e);
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (bus.pmem_resp === 1'b1) got = 1'b1;
    end
    if (!got) begin
      n_vec = n_vec + 1;
      n_err = n_err + 1;
      $display("FAIL resp_timeout: no pmem_resp for address %h, required within 50 cycles", a);
    end
    next_cycle();
    bus.pmem_read  = 1'b0;
    bus.pmem_write = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    bus.pmem_address = '0;
    bus.pmem_wdata   = '0;

    // Reset state
    repeat (3) next_cycle();
    @(negedge clk);
    check("rst_resp",  {255'd0, bus.pmem_resp}, 256'd0);
    check("rst_rdata", bus.pmem_rdata, 256'd0);
    check("rst_proto", {255'd0, proto_error}, 256'd0);
    next_cycle();
    rst_n = 1'b1;

    // Write A5 at cycle 10 (response required at cycle 15), then read it back
    while (cyc < 10) next_cycle();
    issue(1'b0, 1'b1, 32'h0000_0040, {32{8'hA5}}, '0);
    issue(1'b1, 1'b0, 32'h0000_0040, '0, {32{8'hA5}});
    check("proto_clean", {255'd0, proto_error}, 256'd0);

    // Write-back then fill, back to back; responses land 6 cycles apart
    issue(1'b0, 1'b1, 32'h0000_2000, {32{8'h5A}}, '0);
    issue(1'b0, 1'b1, 32'h0000_1000, {32{8'hC3}}, '0);
    issue(1'b1, 1'b0, 32'h0000_2000, '0, {32{8'h5A}});
    issue(1'b1, 1'b0, 32'h0000_1000, '0, {32{8'hC3}});

    // Index aliasing modulo 256 lines
    issue(1'b0, 1'b1, 32'h0000_0020, 256'h1, '0);
    issue(1'b1, 1'b0, 32'h0000_2020, '0, 256'h1);

    // Read and write together: treated as a write, error flagged
    issue(1'b1, 1'b1, 32'h0000_0080, {32{8'h3C}}, '0);
    check("proto_both", {255'd0, proto_error}, 256'd1);
    issue(1'b1, 1'b0, 32'h0000_0080, '0, {32{8'h3C}});
    check("proto_sticky", {255'd0, proto_error}, 256'd1);

    // Reset clears the sticky flag
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    check("proto_after_rst", {255'd0, proto_error}, 256'd0);
    next_cycle();

    // Abandon: read dropped in the second BUSY cycle
    bus.pmem_read    = 1'b1;
    bus.pmem_address = 32'h0000_0040;
    next_cycle();
    next_cycle();
    bus.pmem_read = 1'b0;
    @(negedge clk);
    check("proto_pre_abandon", {255'd0, proto_error}, 256'd0);
    next_cycle();
    @(negedge clk);
    check("proto_abandon", {255'd0, proto_error}, 256'd1);
    repeat (8) next_cycle();
    check("proto_abandon_held", {255'd0, proto_error}, 256'd1);

    // Reset during BUSY discards the uncommitted write
    issue(1'b0, 1'b1, 32'h0000_00C0, {32{8'h11}}, '0);
    bus.pmem_write   = 1'b1;
    bus.pmem_address = 32'h0000_00C0;
    bus.pmem_wdata   = {256{1'b1}};
    next_cycle();
    next_cycle();
    rst_n          = 1'b0;
    bus.pmem_write = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("busy_rst_rdata", bus.pmem_rdata, 256'd0);
    check("busy_rst_proto", {255'd0, proto_error}, 256'd0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    issue(1'b1, 1'b0, 32'h0000_00C0, '0, {32{8'h11}});
    check("proto_final", {255'd0, proto_error}, 256'd0);

    repeat (10) next_cycle();
    check("sb_drained", 256'(sb.size()), 256'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
